// File: rtl/class_router_n.sv
// Class-based router: pops words from one FWFT input FIFO and pushes each to the
// per-class output FIFO selected by its class field, holding or dropping on backpressure.
module class_router_n #(
  parameter int WORD_SIZE   = 12,
  parameter int NUM_CLASSES = 4,
  parameter int CLASS_W     = 2,
  parameter int CLASS_LSB   = 10,
  parameter int CNT_W       = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WORD_SIZE-1:0]         data_in,
  input  logic                         fifo_empty,
  input  logic [NUM_CLASSES-1:0]       fifos_almost_full,
  input  logic                         drop_en,
  input  logic                         cnt_clear,
  output logic                         pop,
  output logic [NUM_CLASSES-1:0]       push,
  output logic [WORD_SIZE-1:0]         data_out,
  output logic [NUM_CLASSES*CNT_W-1:0] class_count,
  output logic [CNT_W-1:0]             drop_count,
  output logic                         busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, ROUTE = 1'b1} state_t;

  state_t                 state;
  logic [WORD_SIZE-1:0]   hold;
  logic [CLASS_W-1:0]     cls;
  logic [NUM_CLASSES-1:0] sel;
  logic                   in_range;
  logic                   blocked;
  logic                   route_push;
  logic                   route_drop;
  logic [CNT_W-1:0]       cnt      [NUM_CLASSES];
  logic [CNT_W-1:0]       cnt_nxt  [NUM_CLASSES];
  logic [CNT_W-1:0]       drop_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Decode the class of the held word and decide push / drop / hold for this cycle.
  always_comb begin
    cls      = hold[CLASS_LSB +: CLASS_W];
    in_range = (32'(cls) < 32'(NUM_CLASSES));
    for (int i = 0; i < NUM_CLASSES; i++) begin
      sel[i] = (cls == CLASS_W'(i));
    end
    // sel is all-zero for an out-of-range class, so blocked cannot alias another FIFO
    blocked    = |(sel & fifos_almost_full);
    route_push = (state == ROUTE) && in_range && !blocked;
    route_drop = (state == ROUTE) && (!in_range || (blocked && drop_en));
  end

  // Next values of the saturating statistics counters; clear overrides any increment.
  always_comb begin
    drop_nxt = drop_count;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      cnt_nxt[i] = cnt[i];
    end
    if (cnt_clear) begin
      drop_nxt = '0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        cnt_nxt[i] = '0;
      end
    end else begin
      drop_nxt = route_drop ? sat_inc(drop_count) : drop_count;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        cnt_nxt[i] = (route_push && sel[i]) ? sat_inc(cnt[i]) : cnt[i];
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CLASSES; g++) begin : g_pack
      assign class_count[g*CNT_W +: CNT_W] = cnt[g];
    end
  endgenerate

  // Router FSM with registered strobes, hold register and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      hold       <= '0;
      pop        <= 1'b0;
      push       <= '0;
      data_out   <= '0;
      busy       <= 1'b0;
      drop_count <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      drop_count <= drop_nxt;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      case (state)
        IDLE: begin
          push <= '0;
          if (!fifo_empty) begin
            hold  <= data_in;
            pop   <= 1'b1;
            busy  <= 1'b1;
            state <= ROUTE;
          end else begin
            pop   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        ROUTE: begin
          pop <= 1'b0;
          if (route_push) begin
            push     <= sel;
            data_out <= hold;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (route_drop) begin
            push  <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            push  <= '0;
            busy  <= 1'b1;
            state <= ROUTE;
          end
        end
        default: begin
          pop   <= 1'b0;
          push  <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_class_router_n.sv
// Directed table-driven bench for class_router_n with a queue-based FWFT FIFO model;
// a second 3-class instance covers the out-of-range class path.
module tb_class_router_n;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] data_in = 12'h000;
  logic        fifo_empty = 1'b1;
  logic [3:0]  af = 4'b0000;
  logic        drop_en = 1'b0;
  logic        cnt_clear = 1'b0;

  logic        pop;
  logic [3:0]  push;
  logic [11:0] data_out;
  logic [19:0] class_count;
  logic [4:0]  drop_count;
  logic        busy;

  logic        pop3;
  logic [2:0]  push3;
  logic [11:0] dout3;
  logic [14:0] cc3;
  logic [4:0]  dc3;
  logic        busy3;

  int checks = 0;
  int errors = 0;
  int pop_cnt = 0;
  int push_cnt = 0;
  logic [11:0] q[$];

  always #5 clk = ~clk;

  class_router_n dut (
    .clk(clk), .reset(reset), .data_in(data_in), .fifo_empty(fifo_empty),
    .fifos_almost_full(af), .drop_en(drop_en), .cnt_clear(cnt_clear),
    .pop(pop), .push(push), .data_out(data_out), .class_count(class_count),
    .drop_count(drop_count), .busy(busy)
  );

  class_router_n #(.NUM_CLASSES(3)) dut3 (
    .clk(clk), .reset(reset), .data_in(data_in), .fifo_empty(fifo_empty),
    .fifos_almost_full(af[2:0]), .drop_en(drop_en), .cnt_clear(cnt_clear),
    .pop(pop3), .push(push3), .data_out(dout3), .class_count(cc3),
    .drop_count(dc3), .busy(busy3)
  );

  typedef struct {
    logic        ld;
    logic [11:0] w;
    logic [3:0]  af;
    logic        de;
    logic        e_pop;
    logic [3:0]  e_push;
    logic [11:0] e_dout;
    logic        e_busy;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(input logic ld, input logic [11:0] w, input logic [3:0] a,
                              input logic de, input logic ep, input logic [3:0] epu,
                              input logic [11:0] ed, input logic eb);
    vec_t v;
    v.ld = ld; v.w = w; v.af = a; v.de = de;
    v.e_pop = ep; v.e_push = epu; v.e_dout = ed; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic upd();
    fifo_empty = (q.size() == 0);
    data_in    = fifo_empty ? 12'h000 : q[0];
  endtask

  // One clock: the FIFO model consumes the head when pop was high during the cycle.
  task automatic tick();
    logic dp;
    dp = pop;
    @(posedge clk);
    #1;
    if (dp) begin
      pop_cnt++;
      if (q.size() > 0) void'(q.pop_front());
    end
    upd();
    if (push != 4'b0000) push_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Routing and throughput
    tbl[0]  = mk(1'b1, 12'h2AB, 4'b0000, 1'b0, 1'b1, 4'b0000, 12'h000, 1'b1);
    tbl[1]  = mk(1'b1, 12'h5CD, 4'b0000, 1'b0, 1'b0, 4'b0001, 12'h2AB, 1'b0);
    tbl[2]  = mk(1'b1, 12'hA12, 4'b0000, 1'b0, 1'b1, 4'b0000, 12'h2AB, 1'b1);
    tbl[3]  = mk(1'b1, 12'hF34, 4'b0000, 1'b0, 1'b0, 4'b0010, 12'h5CD, 1'b0);
    tbl[4]  = mk(1'b0, 12'h000, 4'b0000, 1'b0, 1'b1, 4'b0000, 12'h5CD, 1'b1);
    tbl[5]  = mk(1'b0, 12'h000, 4'b0000, 1'b0, 1'b0, 4'b0100, 12'hA12, 1'b0);
    tbl[6]  = mk(1'b0, 12'h000, 4'b0000, 1'b0, 1'b1, 4'b0000, 12'hA12, 1'b1);
    tbl[7]  = mk(1'b0, 12'h000, 4'b0000, 1'b0, 1'b0, 4'b1000, 12'hF34, 1'b0);
    tbl[8]  = mk(1'b0, 12'h000, 4'b0000, 1'b0, 1'b0, 4'b0000, 12'hF34, 1'b0);
    // Hold mode: class 1 blocked for five ROUTE cycles
    tbl[9]  = mk(1'b1, 12'h4FF, 4'b0010, 1'b0, 1'b1, 4'b0000, 12'hF34, 1'b1);
    tbl[10] = mk(1'b0, 12'h000, 4'b0010, 1'b0, 1'b0, 4'b0000, 12'hF34, 1'b1);
    tbl[11] = mk(1'b0, 12'h000, 4'b0010, 1'b0, 1'b0, 4'b0000, 12'hF34, 1'b1);
    tbl[12] = mk(1'b0, 12'h000, 4'b0010, 1'b0, 1'b0, 4'b0000, 12'hF34, 1'b1);
    tbl[13] = mk(1'b0, 12'h000, 4'b0010, 1'b0, 1'b0, 4'b0000, 12'hF34, 1'b1);
    tbl[14] = mk(1'b0, 12'h000, 4'b0010, 1'b0, 1'b0, 4'b0000, 12'hF34, 1'b1);
    tbl[15] = mk(1'b0, 12'h000, 4'b0000, 1'b0, 1'b0, 4'b0010, 12'h4FF, 1'b0);
    tbl[16] = mk(1'b0, 12'h000, 4'b0000, 1'b0, 1'b0, 4'b0000, 12'h4FF, 1'b0);
    // Drop mode: blocked class-1 word discarded, following class-0 word routed
    tbl[17] = mk(1'b1, 12'h4FF, 4'b0010, 1'b1, 1'b1, 4'b0000, 12'h4FF, 1'b1);
    tbl[18] = mk(1'b1, 12'h123, 4'b0010, 1'b1, 1'b0, 4'b0000, 12'h4FF, 1'b0);
    tbl[19] = mk(1'b0, 12'h000, 4'b0010, 1'b1, 1'b1, 4'b0000, 12'h4FF, 1'b1);
    tbl[20] = mk(1'b0, 12'h000, 4'b0010, 1'b1, 1'b0, 4'b0001, 12'h123, 1'b0);
    tbl[21] = mk(1'b0, 12'h000, 4'b0010, 1'b1, 1'b0, 4'b0000, 12'h123, 1'b0);

    // Reset held for three cycles
    reset = 1'b0;
    upd();
    tick(); tick(); tick();
    chk("rst_outputs", {pop, push, data_out, busy}, 64'h0);
    reset = 1'b1;
    tick();
    chk("rst_rel_outputs", {pop, push, data_out, busy}, 64'h0);
    chk("rst_rel_counts", {class_count, drop_count}, 64'h0);
    chk("rst_rel_dut3", {pop3, push3, dout3, busy3, cc3, dc3}, 64'h0);
    pop_cnt = 0;
    push_cnt = 0;

    for (int i = 0; i < 22; i++) begin
      if (tbl[i].ld) q.push_back(tbl[i].w);
      af = tbl[i].af;
      drop_en = tbl[i].de;
      upd();
      tick();
      chk($sformatf("row%0d pop/push/dout/busy", i), {pop, push, data_out, busy},
          {tbl[i].e_pop, tbl[i].e_push, tbl[i].e_dout, tbl[i].e_busy});
    end
    chk("tbl_pops", 64'(pop_cnt), 64'd7);
    chk("tbl_pushes", 64'(push_cnt), 64'd6);
    chk("tbl_class_count", 64'(class_count), 64'({5'd1, 5'd1, 5'd2, 5'd2}));
    chk("tbl_drop_count", 64'(drop_count), 64'd1);
    chk("tbl_dut3_class_count", 64'(cc3), 64'({5'd1, 5'd2, 5'd2}));
    chk("tbl_dut3_drop_count", 64'(dc3), 64'd2);

    // Reset asserted mid-cycle while ROUTE is issuing pop
    af = 4'b0000;
    drop_en = 1'b0;
    q.push_back(12'h2AB);
    upd();
    tick();
    chk("pre_rst_pop", {pop, busy}, 64'b11);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_outputs", {pop, push, data_out, busy}, 64'h0);
    chk("async_rst_counts", {class_count, drop_count}, 64'h0);
    q.delete();
    upd();
    tick(); tick();
    reset = 1'b1;
    push_cnt = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("no_push_after_rst", 64'(push_cnt), 64'd0);
    chk("idle_after_rst", {pop, busy}, 64'b00);

    // Saturation of class 0 counter, then clear coinciding with a push
    for (int i = 0; i < 40; i++) q.push_back(12'(i));
    upd();
    push_cnt = 0;
    for (int i = 0; i < 82; i++) tick();
    chk("sat_pushes", 64'(push_cnt), 64'd40);
    chk("sat_class0", 64'(class_count[4:0]), 64'd31);
    chk("sat_others", 64'(class_count[19:5]), 64'd0);
    q.push_back(12'h001);
    upd();
    tick();
    cnt_clear = 1'b1;
    tick();
    chk("clear_push", 64'(push), 64'b0001);
    chk("clear_counts", {class_count, drop_count}, 64'h0);
    cnt_clear = 1'b0;
    tick();

    // Out-of-range class on the 3-class instance, drop_en=0
    q.push_back(12'hC00);
    upd();
    tick();
    chk("oor_pop", {pop, pop3}, 64'b11);
    tick();
    chk("oor_dut3_push", 64'(push3), 64'b000);
    chk("oor_dut3_drop", 64'(dc3), 64'd1);
    chk("oor_dut3_busy", 64'(busy3), 64'd0);
    chk("oor_dut4_push", 64'(push), 64'b1000);
    chk("oor_dut4_count", 64'(class_count), 64'({5'd1, 15'd0}));
    tick();
    chk("oor_dut3_idle", {pop3, push3, busy3}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
